// File: rtl/svm_window_scorer.sv
// Linear-SVM window scorer: per-channel multiply-accumulate of HOG features
// against a coefficient RAM, biased and saturated at each window's end.
module svm_window_scorer #(
  parameter  int FEA_I  = 4,
  parameter  int FEA_F  = 8,
  parameter  int N_FEA  = 3780,
  parameter  int N_CH   = 4,
  parameter  int SW_W   = 11,
  localparam int FEA_W  = FEA_I + FEA_F,
  localparam int COEF_W = FEA_W,
  localparam int ADDR_W = $clog2(N_FEA),
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int ACC_W  = 2*FEA_W + $clog2(N_FEA) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              i_valid,
  input  logic [CH_W-1:0]   i_ch,
  input  logic [FEA_W-1:0]  i_fea,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic              write_en,
  input  logic [COEF_W-1:0] i_data_a,
  output logic [COEF_W-1:0] o_data_a,
  input  logic [FEA_W-1:0]  bias,
  input  logic              b_load,
  output logic              o_valid,
  output logic [CH_W-1:0]   o_ch,
  output logic [SW_W-1:0]   sw_id,
  output logic [FEA_W-1:0]  result,
  output logic              is_person
);

  localparam int PW = 2*FEA_W;

  logic [COEF_W-1:0]        mem  [N_FEA];
  logic [ADDR_W-1:0]        fcnt [N_CH];
  logic signed [ACC_W-1:0]  acc  [N_CH];
  logic [SW_W-1:0]          wcnt [N_CH];
  logic signed [FEA_W-1:0]  bias_reg;

  logic                     s1_v, s1_last;
  logic [CH_W-1:0]          s1_ch;
  logic signed [FEA_W-1:0]  s1_fea, s1_coef;

  logic                     s2_v, s2_last;
  logic [CH_W-1:0]          s2_ch;
  logic signed [PW-1:0]     s2_prod;

  logic                     s3_v;
  logic [CH_W-1:0]          s3_ch;
  logic signed [ACC_W-1:0]  s3_sum;

  logic                     take, last0;
  logic signed [ACC_W-1:0]  prod_x, bias_x, sum_nx, sh;
  logic [ACC_W-FEA_W:0]     hi;
  logic [FEA_W-1:0]         sat;

  assign take  = i_valid && (int'(i_ch) < N_CH);
  assign last0 = fcnt[i_ch] == ADDR_W'(N_FEA-1);

  assign prod_x = {{(ACC_W-PW){s2_prod[PW-1]}}, s2_prod};
  // bias carries FEA_F fraction bits; align it to the product's 2*FEA_F
  assign bias_x = {{(ACC_W-FEA_W-FEA_F){bias_reg[FEA_W-1]}},
                   bias_reg, {FEA_F{1'b0}}};
  assign sum_nx = acc[s2_ch] + prod_x + bias_x;

  assign sh  = s3_sum >>> FEA_F;
  assign hi  = sh[ACC_W-1:FEA_W-1];
  assign sat = (&hi || ~|hi) ? sh[FEA_W-1:0] :
               sh[ACC_W-1]   ? {1'b1, {(FEA_W-1){1'b0}}} :
                               {1'b0, {(FEA_W-1){1'b1}}};

  always_ff @(posedge clk) begin
    if (write_en) mem[addr_a] <= i_data_a;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < N_CH; c++) begin
        fcnt[c] <= '0;
        acc[c]  <= '0;
        wcnt[c] <= '0;
      end
      bias_reg  <= '0;
      o_data_a  <= '0;
      s1_v      <= 1'b0;
      s1_last   <= 1'b0;
      s1_ch     <= '0;
      s1_fea    <= '0;
      s1_coef   <= '0;
      s2_v      <= 1'b0;
      s2_last   <= 1'b0;
      s2_ch     <= '0;
      s2_prod   <= '0;
      s3_v      <= 1'b0;
      s3_ch     <= '0;
      s3_sum    <= '0;
      o_valid   <= 1'b0;
      o_ch      <= '0;
      sw_id     <= '0;
      result    <= '0;
      is_person <= 1'b0;
    end else begin
      o_data_a <= mem[addr_a];
      if (b_load) bias_reg <= bias;
      if (clear) begin
        for (int c = 0; c < N_CH; c++) begin
          fcnt[c] <= '0;
          acc[c]  <= '0;
          wcnt[c] <= '0;
        end
        s1_v    <= 1'b0;
        s2_v    <= 1'b0;
        s3_v    <= 1'b0;
        o_valid <= 1'b0;
      end else begin
        s1_v <= take;
        if (take) begin
          s1_ch      <= i_ch;
          s1_last    <= last0;
          s1_fea     <= i_fea;
          s1_coef    <= mem[fcnt[i_ch]];
          fcnt[i_ch] <= last0 ? '0 : fcnt[i_ch] + 1'b1;
        end
        s2_v <= s1_v;
        if (s1_v) begin
          s2_ch   <= s1_ch;
          s2_last <= s1_last;
          s2_prod <= s1_fea * s1_coef;
        end
        s3_v <= s2_v && s2_last;
        if (s2_v) begin
          if (s2_last) begin
            acc[s2_ch] <= '0;
            s3_ch      <= s2_ch;
            s3_sum     <= sum_nx;
          end else begin
            acc[s2_ch] <= acc[s2_ch] + prod_x;
          end
        end
        o_valid <= s3_v;
        if (s3_v) begin
          o_ch        <= s3_ch;
          sw_id       <= wcnt[s3_ch];
          wcnt[s3_ch] <= wcnt[s3_ch] + 1'b1;
          result      <= sat;
          is_person   <= !sat[FEA_W-1] && |sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_svm_window_scorer.sv
// Scoreboard bench for svm_window_scorer: stimulus pushes expected scores,
// a monitor pops and compares on every o_valid strobe.
module tb_svm_window_scorer;

  localparam int FEA_W  = 12;
  localparam int N_FEA  = 8;
  localparam int N_CH   = 2;
  localparam int SW_W   = 11;
  localparam int CH_W   = 1;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear, i_valid, write_en, b_load;
  logic [CH_W-1:0]   i_ch;
  logic [FEA_W-1:0]  i_fea, i_data_a, bias;
  logic [ADDR_W-1:0] addr_a;
  logic [FEA_W-1:0]  o_data_a, result;
  logic              o_valid, is_person;
  logic [CH_W-1:0]   o_ch;
  logic [SW_W-1:0]   sw_id;

  svm_window_scorer #(
    .FEA_I(4), .FEA_F(8), .N_FEA(N_FEA), .N_CH(N_CH), .SW_W(SW_W)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .i_valid(i_valid), .i_ch(i_ch), .i_fea(i_fea),
    .addr_a(addr_a), .write_en(write_en), .i_data_a(i_data_a),
    .o_data_a(o_data_a), .bias(bias), .b_load(b_load),
    .o_valid(o_valid), .o_ch(o_ch), .sw_id(sw_id),
    .result(result), .is_person(is_person)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH_W-1:0]  ch;
    logic [SW_W-1:0]  sw;
    logic [FEA_W-1:0] res;
    logic             person;
    int               cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (o_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL strobe: got result %0h expected no strobe", result);
      end else begin
        e = q.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("is_person", 32'(is_person), 32'(e.person));
        check("o_ch", 32'(o_ch), 32'(e.ch));
        check("sw_id", 32'(sw_id), 32'(e.sw));
        check("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic push(input logic [CH_W-1:0] ch, input int sw,
                      input logic [FEA_W-1:0] res, input logic p);
    q.push_back('{ch, SW_W'(sw), res, p, cyc + 4});
  endtask

  task automatic beat(input logic [CH_W-1:0] ch,
                      input logic [FEA_W-1:0] fea);
    @(negedge clk);
    i_valid = 1'b1;
    i_ch    = ch;
    i_fea   = fea;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_valid = 1'b0;
    end
  endtask

  task automatic window(input logic [CH_W-1:0] ch,
                        input logic [FEA_W-1:0] fea, input int sw,
                        input logic [FEA_W-1:0] res, input logic p);
    for (int i = 0; i < N_FEA; i++) begin
      beat(ch, fea);
      if (i == N_FEA-1) push(ch, sw, res, p);
    end
  endtask

  task automatic wcoef(input logic [FEA_W-1:0] val);
    for (int a = 0; a < N_FEA; a++) begin
      @(negedge clk);
      i_valid  = 1'b0;
      write_en = 1'b1;
      addr_a   = ADDR_W'(a);
      i_data_a = val;
    end
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    i_valid = 1'b0;
    clear   = 1'b1;
    @(negedge clk);
    clear   = 1'b0;
  endtask

  task automatic set_bias(input logic [FEA_W-1:0] b);
    @(negedge clk);
    b_load = 1'b1;
    bias   = b;
    @(negedge clk);
    b_load = 1'b0;
  endtask

  task automatic check_zero();
    check("rst_o_valid", 32'(o_valid), 0);
    check("rst_o_ch", 32'(o_ch), 0);
    check("rst_sw_id", 32'(sw_id), 0);
    check("rst_result", 32'(result), 0);
    check("rst_is_person", 32'(is_person), 0);
    check("rst_o_data_a", 32'(o_data_a), 0);
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; i_valid = 1'b0; write_en = 1'b0;
    b_load = 1'b0; i_ch = '0; i_fea = '0; i_data_a = '0;
    bias = '0; addr_a = '0;
    repeat (2) @(negedge clk);
    check_zero();
    rst = 1'b1;

    // single window, unit coefficients
    wcoef(12'h100);
    window(1'b0, 12'h080, 0, 12'h400, 1'b1);
    idle(5);

    // interleaved channels
    do_clear();
    for (int i = 0; i < 16; i++) begin
      beat(CH_W'(i % 2), (i % 2) ? 12'hF80 : 12'h080);
      if (i == 14) push(1'b0, 0, 12'h400, 1'b1);
      if (i == 15) push(1'b1, 0, 12'hC00, 1'b0);
    end
    idle(5);

    // saturation both ways
    wcoef(12'h700);
    window(1'b0, 12'h700, 1, 12'h7FF, 1'b1);
    window(1'b0, 12'h900, 2, 12'h800, 1'b0);
    idle(5);
    wcoef(12'h100);

    // bias, then bias reload racing the last beat's accumulate
    set_bias(12'hC00);
    window(1'b0, 12'h080, 3, 12'h000, 1'b0);
    idle(5);
    window(1'b0, 12'h080, 4, 12'h000, 1'b0);
    idle(1);
    @(negedge clk);
    b_load = 1'b1;
    bias   = 12'h000;
    @(negedge clk);
    b_load = 1'b0;
    idle(4);
    window(1'b0, 12'h080, 5, 12'h400, 1'b1);
    idle(5);

    // clear mid-window, concurrent beat dropped
    for (int i = 0; i < 3; i++) beat(1'b0, 12'h080);
    @(negedge clk);
    clear   = 1'b1;
    i_valid = 1'b1;
    i_ch    = 1'b0;
    i_fea   = 12'h7FF;
    @(negedge clk);
    clear   = 1'b0;
    i_valid = 1'b0;
    window(1'b0, 12'h080, 0, 12'h400, 1'b1);
    idle(5);

    // window count, then reset mid-window
    do_clear();
    window(1'b0, 12'h080, 0, 12'h400, 1'b1);
    window(1'b0, 12'h080, 1, 12'h400, 1'b1);
    window(1'b0, 12'h080, 2, 12'h400, 1'b1);
    for (int i = 0; i < 3; i++) beat(1'b0, 12'h080);
    @(negedge clk);
    i_valid = 1'b0;
    rst     = 1'b0;
    #1;
    check_zero();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    window(1'b0, 12'h080, 0, 12'h400, 1'b1);
    idle(5);

    // coefficient write during scoring with read-back
    for (int i = 0; i < N_FEA; i++) begin
      beat(1'b0, 12'h080);
      if (i == 4) begin
        write_en = 1'b1;
        addr_a   = '0;
        i_data_a = 12'h200;
      end
      if (i == 5) begin
        check("rd_before_wr", 32'(o_data_a), 32'h100);
        write_en = 1'b0;
      end
      if (i == 6) check("rd_after_wr", 32'(o_data_a), 32'h200);
      if (i == N_FEA-1) push(1'b0, 1, 12'h400, 1'b1);
    end
    window(1'b0, 12'h080, 2, 12'h480, 1'b1);

    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
    idle(2);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/svm_window_scorer.md
# svm_window_scorer

Parametrised linear-SVM scoring engine for the HOG pipeline. Takes normalised HOG features for up to N_CH interleaved slide windows, multiplies each by its coefficient from an internal coefficient RAM and accumulates per window. On each window's last feature it adds the bias, emits a saturated score with person/no-person decision, channel and window index, and sits between the block-normalisation stage and the detection-result collector. It supersedes the single-window SVM stage with multi-window channels, a synchronous frame clear, and score saturation.

## Interface
- FEA_I, 4, integer bits of feature, coefficient and score (signed two's complement)
- FEA_F, 8, fractional bits of feature, coefficient and score
- N_FEA, 3780, features per slide window; also the coefficient RAM depth
- N_CH, 4, independent interleaved window channels
- SW_W, 11, slide-window index width
- Derived (local): FEA_W = FEA_I+FEA_F; COEF_W = FEA_W; ADDR_W = clog2(N_FEA); CH_W = max(1, clog2(N_CH)); ACC_W = 2*FEA_W + clog2(N_FEA) + 1
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- clear  in  1  synchronous frame restart
- i_valid  in  1  feature beat valid; every beat is accepted, no backpressure
- i_ch  in  CH_W  channel of the beat; values >= N_CH are ignored
- i_fea  in  FEA_W  signed feature
- addr_a  in  ADDR_W  coefficient load address
- write_en  in  1  coefficient write strobe
- i_data_a  in  COEF_W  coefficient write data
- o_data_a  out  COEF_W  coefficient read-back at addr_a, registered
- bias  in  FEA_W  signed bias value
- b_load  in  1  capture bias into the bias register
- o_valid  out  1  one-cycle score strobe
- o_ch  out  CH_W  channel of the score
- sw_id  out  SW_W  window index within the channel
- result  out  FEA_W  saturated signed score
- is_person  out  1  result > 0 (strict)

## Operation
- Per channel: feature counter fcnt[c] (0..N_FEA-1), accumulator acc[c] (ACC_W signed), window counter wcnt[c] (SW_W).
- Stage 0 (accept): i_valid with i_ch < N_CH reads coefficient RAM at fcnt[i_ch]. Then fcnt increments, wrapping N_FEA-1 -> 0. Tags the beat with ch and last = (fcnt == N_FEA-1).
- Stage 1: product = fea * coef, full 2*FEA_W signed, 2*FEA_F fraction bits.
- Stage 2: acc[ch] <= acc[ch] + sext(product). On the last beat, acc[ch] <= 0 and sum = acc + product + (bias_reg <<< FEA_F) is latched to stage 3.
- Stage 3: result = sum >>> FEA_F (arithmetic), saturated to [-2^(FEA_W-1), 2^(FEA_W-1)-1]. Drives o_valid, o_ch, sw_id = wcnt[ch]; wcnt[ch] then increments, wrapping at 2^SW_W.
- Same-channel beats on consecutive cycles are legal. Stage 2 feedback is single-cycle and needs no bypass.
- At most one completion per cycle, because there is one input beat per cycle.
- Coefficient port: write_en writes i_data_a at addr_a. o_data_a returns mem[addr_a] one cycle later, read-before-write. A stage 0 read of the address being written in the same cycle returns the old value.
- b_load captures bias the next edge. A completion in stage 2 in the same cycle as b_load uses the old bias.
- clear (priority over i_valid): zeroes all fcnt, acc, wcnt. Invalidates stages 1-3, so in-flight beats never produce o_valid. The beat presented with clear is dropped. Coefficient RAM and bias register are untouched.
- i_ch >= N_CH: the beat is discarded and no state changes.

## Timing
- Reset: o_valid=0, o_ch=0, sw_id=0, result=0, is_person=0, o_data_a=0, bias_reg=0; all counters and accumulators 0. RAM contents are undefined.
- Latency: o_valid asserts 3 cycles after the edge accepting the last feature (accept at edge T, o_valid high after edge T+3).
- Throughput: one feature per cycle sustained, any channel mix.
- o_valid is high exactly one cycle per completed window. Outputs other than o_valid hold their last value between strobes.
- Reset asserted mid-window: everything clears immediately and the partial window is lost.

## Test plan
- N_FEA=8, N_CH=2, all coefs 0x100 (1.0), bias 0. Eight ch0 beats of fea 0x080 (0.5) -> one o_valid 3 cycles after the 8th beat: result 0x400 (4.0), is_person 1, o_ch 0, sw_id 0.
- Alternate ch0 fea 0x080 and ch1 fea 0xF80 (-0.5), 16 beats. Expected: ch0 gives result 0x400, is_person 1; ch1 gives result 0xC00, is_person 0. The two strobes are on consecutive cycles and both have sw_id 0.
- Saturation: coefs 0x700, fea 0x700 ×8 -> result 0x7FF. With fea 0x900 (-7.0) -> result 0x800.
- Bias: b_load bias 0xC00 (-4.0), then repeat scenario 1 -> result 0x000, is_person 0. Assert b_load in the last beat's stage 2 cycle -> old bias is used.
- Clear: 3 ch0 beats, then clear with a concurrent beat, then 8 ch0 beats of 0x080 -> exactly one strobe, result 0x400, sw_id 0.
- Window count and reset: 3 back-to-back ch0 windows -> sw_id 0,1,2. Assert rst mid 4th window -> all outputs 0. A following window gives sw_id 0. Read-back of a coefficient written during scoring returns the new value on o_data_a one cycle after the read.
